// File: rtl/freq_meter.sv
// Gated frequency counter: synchronises an asynchronous input, counts its rising
// edges over a GATE_CYCLES window and publishes the saturated count with a valid strobe.
module freq_meter #(
  parameter int GATE_CYCLES = 12000000,
  parameter int GATE_WIDTH  = 24,
  parameter int WIDTH       = 16,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic             input_clk,
  input  logic             reset,
  input  logic             signal_in,
  input  logic             start,
  output logic             busy,
  output logic             count_valid,
  output logic [WIDTH-1:0] count_out,
  output logic             overflow
);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  localparam logic [GATE_WIDTH-1:0] GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0]      EDGE_MAX  = {WIDTH{1'b1}};

  state_t                r_state;
  state_t                w_next;
  logic                  r_s1;
  logic                  r_s2;
  logic                  r_s3;
  logic                  w_rise;
  logic [GATE_WIDTH-1:0] r_gate;
  logic [WIDTH-1:0]      r_edge;
  logic                  r_win_ovf;
  logic                  w_last;
  logic                  w_edge_sat;
  logic                  r_busy;
  logic                  r_valid;
  logic [WIDTH-1:0]      r_count;
  logic                  r_ovf;

  // Two-flop synchroniser plus history flop for rising-edge detection
  always_ff @(posedge input_clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= signal_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise     = r_s2 & ~r_s3;
  assign w_last     = (r_state == MEASURE) && (r_gate == GATE_LAST);
  assign w_edge_sat = (r_edge == EDGE_MAX);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start || CONTINUOUS) begin
          w_next = MEASURE;
        end else begin
          w_next = IDLE;
        end
      end
      MEASURE: begin
        if (w_last && !CONTINUOUS) begin
          w_next = IDLE;
        end else begin
          w_next = MEASURE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register; busy is registered alongside it
  always_ff @(posedge input_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == MEASURE);
    end
  end

  // Gate and edge counters; both sit at zero outside a window so a new window starts clean
  always_ff @(posedge input_clk) begin
    if (reset) begin
      r_gate    <= {GATE_WIDTH{1'b0}};
      r_edge    <= {WIDTH{1'b0}};
      r_win_ovf <= 1'b0;
    end else if ((r_state == MEASURE) && !w_last) begin
      r_gate <= r_gate + GATE_WIDTH'(1);
      if (w_rise) begin
        if (w_edge_sat) begin
          r_win_ovf <= 1'b1;
        end else begin
          r_edge <= r_edge + WIDTH'(1);
        end
      end
    end else begin
      r_gate    <= {GATE_WIDTH{1'b0}};
      r_edge    <= {WIDTH{1'b0}};
      r_win_ovf <= 1'b0;
    end
  end

  // Result publication on the last window cycle, including a rise landing in that cycle
  always_ff @(posedge input_clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_count <= {WIDTH{1'b0}};
      r_ovf   <= 1'b0;
    end else if (w_last) begin
      r_valid <= 1'b1;
      r_count <= w_edge_sat ? EDGE_MAX : (r_edge + WIDTH'(w_rise));
      r_ovf   <= r_win_ovf | (w_rise & w_edge_sat);
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign busy        = r_busy;
  assign count_valid = r_valid;
  assign count_out   = r_count;
  assign overflow    = r_ovf;

endmodule
